bp_inv_affine_pipe: RTL and testbench
=====================================

BP_INV_AFFINE_PIPE -- requirements
Module: bp_inv_affine_pipe

Interface
REQ-001 Parameter d, default 2: number of Boolean shares per bit (d >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; clears all state.
REQ-004 flush  input  1  synchronous clear of buffered words; active-high.
REQ-005 in_valid  input  1  in_sh holds a word to transfer.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_sh  input  32*d  masked 32-bit word (4 bytes, byte 0 = bits 7:0); share k of bit j at index j*d+k.
REQ-008 out_valid  output  1  out_sh holds a result word.
REQ-009 out_ready  input  1  consumer accepts out_sh this cycle.
REQ-010 out_sh  output  32*d  masked result, same bit/share layout as in_sh.
REQ-011 occ  output  2  number of buffered words, 0..2.

Function
REQ-012 Per byte s, the unmasked result SHALL be the AES inverse affine map b_i = s_((i+2)mod 8) ^ s_((i+5)mod 8) ^ s_((i+7)mod 8) ^ c_i, with c = 0x05.
REQ-013 The linear part SHALL be applied to each share independently; no cross-share logic anywhere in the block.
REQ-014 Constant 0x05 SHALL be XORed into share 0 of every byte only; shares 1..d-1 carry no constant.
REQ-015 The transform SHALL be computed combinationally on in_sh and the result written into a 2-entry FIFO; the FIFO stores only transformed shares.
REQ-016 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-017 in_ready SHALL equal (occ != 2); it SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL equal (occ != 0); out_sh SHALL be the oldest entry, driven directly from a register.
REQ-019 Latency: a word accepted at edge N SHALL be visible on out_sh with out_valid=1 after edge N when occ was 0.
REQ-020 Simultaneous push and pop with occ=1 SHALL leave occ=1, with the new word becoming the head after the pop.
REQ-021 When occ=2, no push occurs; a pop SHALL give occ=1 at the next edge.
REQ-022 Pop with occ=0 and push with occ=2 SHALL be ignored; no state change and no wrap corruption.
REQ-023 Read/write pointers are 1 bit each and SHALL wrap 1->0.
REQ-024 Order SHALL be strictly FIFO.
REQ-025 flush=1 SHALL set occ=0 at the next edge and discard any same-cycle push.
REQ-026 Storage registers SHALL be cleared to 0 on pop/flush so no stale shares remain on out_sh.

Reset
REQ-027 While rst_n=0, independent of clk: occ=0, out_valid=0, in_ready=1, pointers=0, out_sh=0, all storage=0.
REQ-028 Deassertion of rst_n mid-transfer SHALL leave no partial word; the first word accepted after reset SHALL be output first.

Verification
REQ-029 d=2, in_sh unmasked 0x63636363 (share1 = random R) -> out unmasked 0x00000000; out share1 = per-share linear image of R.
REQ-030 Unmasked 0x00000000 with share1=0 -> out share0 = 0x05050505, share1 = 0; out_valid rises one edge after acceptance.
REQ-031 Push 3 words with out_ready=0 -> occ reaches 2, in_ready=0, third word not accepted; drain returns words 1 and 2 in order.
REQ-032 Continuous in_valid=out_ready=1 for 8 words -> one word per cycle after the first, occ stays 1, no loss or reordering.
REQ-033 occ=2, then flush=1 with in_valid=1 -> occ=0, out_valid=0, out_sh=0 next cycle; flushed and pushed words never appear.
REQ-034 Assert rst_n=0 between clock edges with occ=2 -> outputs reach reset values immediately; all 256 byte values checked against a reference InvSBox affine after restart.

Source files
------------

// File: rtl/bp_inv_affine_pipe.sv
// ---------------------------------------------------------------------------
// bp_inv_affine_pipe
//
// Masked AES inverse-affine stage followed by a 2-entry FIFO.
//
// Each 32-bit word arrives as d Boolean shares per bit. The inverse affine
// map is applied to every share on its own. The constant 0x05 is added to
// share 0 of each byte only, so the shares recombine to the unmasked result.
// Only transformed shares are ever stored. out_sh comes straight from a
// register that always holds the FIFO head.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears all state
//   flush      synchronous clear of buffered words, wins over a same-cycle push
//   in_valid   in_sh carries a word to transfer
//   in_ready   block can take a word (occ != 2)
//   in_sh      masked input word, share k of bit j at index j*d+k
//   out_valid  out_sh carries a result word (occ != 0)
//   out_ready  consumer takes out_sh this cycle
//   out_sh     masked result word, same layout as in_sh
//   occ        number of buffered words, 0..2
// ---------------------------------------------------------------------------
module bp_inv_affine_pipe #(
  parameter int d = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*d-1:0] in_sh,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] out_sh,
  output logic [1:0]      occ
);

  localparam int         W        = 32 * d;
  localparam logic [7:0] C_AFFINE = 8'h05;

  typedef logic [W-1:0] word_t;

  // -------------------------------------------------------------------------
  // Share-wise inverse affine map (pure wiring plus XORs).
  // b_i = s_(i+2) ^ s_(i+5) ^ s_(i+7) ^ c_i, where c is applied to share 0 only.
  // Every term taken from one share stays in that share.
  // -------------------------------------------------------------------------
  word_t w_xform;

  for (genvar g_byte = 0; g_byte < 4; g_byte++) begin : g_bytes
    for (genvar g_bit = 0; g_bit < 8; g_bit++) begin : g_bits
      for (genvar g_sh = 0; g_sh < d; g_sh++) begin : g_shares
        localparam int OUT_IDX = (g_byte*8 + g_bit)*d + g_sh;
        localparam int IN_A    = (g_byte*8 + (g_bit+2)%8)*d + g_sh;
        localparam int IN_B    = (g_byte*8 + (g_bit+5)%8)*d + g_sh;
        localparam int IN_C    = (g_byte*8 + (g_bit+7)%8)*d + g_sh;
        if (g_sh == 0) begin : g_const
          assign w_xform[OUT_IDX] = in_sh[IN_A] ^ in_sh[IN_B] ^ in_sh[IN_C]
                                    ^ C_AFFINE[g_bit];
        end else begin : g_plain
          assign w_xform[OUT_IDX] = in_sh[IN_A] ^ in_sh[IN_B] ^ in_sh[IN_C];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO state
  // -------------------------------------------------------------------------
  word_t       r_mem [2];
  word_t       r_out_sh;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_occ;

  word_t       w_mem_nxt [2];
  logic        w_wr_ptr_nxt;
  logic        w_rd_ptr_nxt;
  logic [1:0]  w_occ_nxt;
  logic        w_push;
  logic        w_pop;

  assign in_ready  = (r_occ != 2'd2);
  assign out_valid = (r_occ != 2'd0);
  assign occ       = r_occ;
  assign out_sh    = r_out_sh;

  // Flush discards the word on in_sh and makes the pop irrelevant.
  assign w_push = in_valid  & in_ready  & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Next-state computation. With occ=1 the write and read pointers differ,
  // so a simultaneous clear-on-pop and write never hit the same entry. With
  // occ=0 or occ=2 only one of the two operations can occur.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    w_mem_nxt    = r_mem;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_occ_nxt    = r_occ;

    if (flush) begin
      w_mem_nxt[0] = '0;
      w_mem_nxt[1] = '0;
      w_wr_ptr_nxt = 1'b0;
      w_rd_ptr_nxt = 1'b0;
      w_occ_nxt    = 2'd0;
    end else begin
      if (w_pop) begin
        // Clear the vacated entry so no stale shares remain in storage.
        w_mem_nxt[r_rd_ptr] = '0;
        w_rd_ptr_nxt        = ~r_rd_ptr;
      end
      if (w_push) begin
        w_mem_nxt[r_wr_ptr] = w_xform;
        w_wr_ptr_nxt        = ~r_wr_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_occ_nxt = r_occ + 2'd1;
        2'b01:   w_occ_nxt = r_occ - 2'd1;
        default: w_occ_nxt = r_occ;
      endcase
    end
  end

  // NOTE: the storage array is reset along with the control state. This keeps
  // shares from a previous run from reaching out_sh after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_out_sh <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      // NOTE: state updates are non-blocking so every register samples the
      // pre-edge values, independent of statement order.
      r_mem[0] <= w_mem_nxt[0];
      r_mem[1] <= w_mem_nxt[1];
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_occ    <= w_occ_nxt;
      // Mirror of the next head. An empty FIFO yields 0 because vacated
      // entries are cleared.
      r_out_sh <= w_mem_nxt[w_rd_ptr_nxt];
    end
  end

endmodule

// File: tb/tb_bp_inv_affine_pipe.sv
// ---------------------------------------------------------------------------
// tb_bp_inv_affine_pipe
//
// Directed bench for bp_inv_affine_pipe with d=2. Inputs change 1 ns after a
// rising edge, and outputs are sampled at that same point. Expected results
// come from a rotation form of the inverse affine map. The full byte sweep
// relies on the forward AES affine map, so it has an independent reference.
// ---------------------------------------------------------------------------
module tb_bp_inv_affine_pipe;

  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [63:0]   in_sh = '0;
  logic          in_ready;
  logic          out_valid;
  logic [63:0]   out_sh;
  logic [1:0]    occ;

  int n_cmp = 0;
  int n_err = 0;

  bp_inv_affine_pipe #(.d(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh     (in_sh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh    (out_sh),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  // ---- helpers -------------------------------------------------------------
  function automatic logic [63:0] pack(input logic [31:0] s0, input logic [31:0] s1);
    logic [63:0] v;
    for (int j = 0; j < 32; j++) begin
      v[2*j]   = s0[j];
      v[2*j+1] = s1[j];
    end
    return v;
  endfunction

  function automatic logic [31:0] share(input logic [63:0] v, input int k);
    logic [31:0] s;
    for (int j = 0; j < 32; j++) s[j] = v[2*j+k];
    return s;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Linear part of the inverse affine map in rotation form.
  function automatic logic [7:0] lin8(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6);
  endfunction

  function automatic logic [31:0] lin32(input logic [31:0] x);
    return {lin8(x[31:24]), lin8(x[23:16]), lin8(x[15:8]), lin8(x[7:0])};
  endfunction

  // Forward AES affine map; the block under test must invert it.
  function automatic logic [7:0] fwd8(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  // Expected masked output for input shares (s0, s1).
  function automatic logic [63:0] exp_out(input logic [31:0] s0, input logic [31:0] s1);
    return pack(lin32(s0) ^ 32'h05050505, lin32(s1));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- stimulus ------------------------------------------------------------
  logic [31:0] r_mask;
  logic [31:0] s0_w [3];
  logic [31:0] s1_w [3];
  logic [31:0] u_w;
  logic [31:0] m_w;
  logic [31:0] exp_u;
  logic [7:0]  v0, v1, v2, v3;

  initial begin
    // Reset state while rst_n is low.
    #2;
    check("rst_occ",       64'(occ),       64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_sh",    out_sh,         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Hand-computed constant: inverse affine of 0x63 is 0x00.
    check("lin8_63", 64'(lin8(8'h63) ^ 8'h05), 64'h00);

    // Zero word: share0 becomes 0x05050505 and share1 stays 0, one edge later.
    in_sh = pack(32'h0, 32'h0);
    in_valid = 1'b1;
    check("zero_pre_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("zero_valid", 64'(out_valid), 64'd1);
    check("zero_occ",   64'(occ),       64'd1);
    check("zero_out",   out_sh,         pack(32'h05050505, 32'h0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("zero_pop_occ", 64'(occ), 64'd0);
    check("zero_pop_sh",  out_sh,   64'd0);

    // 0x63636363 masked with R: unmasked result 0, share1 = linear image of R.
    r_mask = 32'h3c5a96e1;
    in_sh = pack(32'h63636363 ^ r_mask, r_mask);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s63_unmasked", 64'(share(out_sh, 0) ^ share(out_sh, 1)), 64'd0);
    check("s63_share1",   64'(share(out_sh, 1)), 64'(lin32(r_mask)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-pressure: three pushes with out_ready=0 leave only two words stored.
    s0_w[0] = 32'h11223344; s1_w[0] = 32'hdeadbeef;
    s0_w[1] = 32'ha5a5f00f; s1_w[1] = 32'h0badcafe;
    s0_w[2] = 32'h77777777; s1_w[2] = 32'h12345678;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sh = pack(s0_w[i], s1_w[i]);
      tick();
    end
    in_valid = 1'b0;
    check("full_occ",      64'(occ),      64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head",     out_sh,        exp_out(s0_w[0], s1_w[0]));
    out_ready = 1'b1;
    tick();
    check("drain_occ1",  64'(occ), 64'd1);
    check("drain_word2", out_sh,   exp_out(s0_w[1], s1_w[1]));
    tick();
    out_ready = 1'b0;
    check("drain_occ0",   64'(occ),       64'd0);
    check("drain_valid",  64'(out_valid), 64'd0);
    check("drain_sh0",    out_sh,         64'd0);

    // Streaming: 8 words with in_valid=out_ready=1, one word per cycle.
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      u_w = 32'h9e3779b9 * (k + 1);
      m_w = 32'h5bd1e995 ^ (k << 8);
      in_sh = pack(u_w, m_w);
      tick();
      check($sformatf("stream%0d_occ", k), 64'(occ), 64'd1);
      check($sformatf("stream%0d_sh", k), out_sh, exp_out(u_w, m_w));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_end_occ", 64'(occ), 64'd0);

    // Flush with a same-cycle push: everything is discarded.
    in_valid = 1'b1;
    in_sh = pack(32'hcafef00d, 32'h0);
    tick();
    in_sh = pack(32'hfeedface, 32'h1);
    tick();
    check("pre_flush_occ", 64'(occ), 64'd2);
    flush = 1'b1;
    in_sh = pack(32'h13579bdf, 32'h2);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_occ",      64'(occ),       64'd0);
    check("flush_valid",    64'(out_valid), 64'd0);
    check("flush_sh",       out_sh,         64'd0);
    check("flush_in_ready", 64'(in_ready),  64'd1);
    in_valid = 1'b1;
    in_sh = pack(32'h2468ace0, 32'h0f0f0f0f);
    tick();
    in_valid = 1'b0;
    check("post_flush_head", out_sh, exp_out(32'h2468ace0, 32'h0f0f0f0f));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_flush_empty", 64'(occ), 64'd0);

    // Asynchronous reset between edges with the FIFO full.
    in_valid = 1'b1;
    in_sh = pack(32'h01020304, 32'haaaa5555);
    tick();
    tick();
    check("pre_rst_occ", 64'(occ), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_occ",      64'(occ),       64'd0);
    check("arst_valid",    64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready),  64'd1);
    check("arst_sh",       out_sh,         64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All 256 byte values: feeding the forward affine of v must return v.
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int w = 0; w < 64; w++) begin
      v0 = 8'(4*w);
      v1 = 8'(4*w + 1);
      v2 = 8'(4*w + 2);
      v3 = 8'(4*w + 3);
      u_w   = {fwd8(v3), fwd8(v2), fwd8(v1), fwd8(v0)};
      exp_u = {v3, v2, v1, v0};
      m_w   = $urandom;
      in_sh = pack(u_w ^ m_w, m_w);
      tick();
      check($sformatf("sweep%0d_unmasked", w),
            64'(share(out_sh, 0) ^ share(out_sh, 1)), 64'(exp_u));
      check($sformatf("sweep%0d_share1", w), 64'(share(out_sh, 1)), 64'(lin32(m_w)));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("sweep_end_occ", 64'(occ), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
